// File: rtl/ex_unit_mc.sv
// Multi-cycle execute unit: registered one-cycle base ALU with valid/ready handshake.
// Iterative RV32M multiply/divide is built only when EX_MULDIV_EN is defined.
module ex_unit_mc #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         op_i,
    input  logic [XLEN-1:0]    a_i,
    input  logic [XLEN-1:0]    b_i,
    input  logic [XLEN-1:0]    link_i,
    input  logic [RADDR_W-1:0] rd_i,
    input  logic               we_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_data,
    output logic [RADDR_W-1:0] out_rd,
    output logic               out_we,
    output logic               out_illegal,
    output logic               busy
);
    localparam int SHW = $clog2(XLEN);

`ifdef EX_MULDIV_EN
    typedef enum logic [1:0] {IDLE, DONE, BUSY} state_t;
`else
    typedef enum logic [0:0] {IDLE, DONE} state_t;
`endif

    state_t          state, state_nxt, start_state;
    logic            accept, is_md, op_legal, alu_legal;
    logic [XLEN-1:0] alu_res;
    logic [SHW-1:0]  shamt;

    assign shamt  = b_i[SHW-1:0];
    assign accept = in_valid && in_ready;

    always_comb begin
        alu_res   = '0;
        alu_legal = 1'b1;
        case (op_i)
            5'b00000: alu_res = a_i + b_i;
            5'b00001: alu_res = a_i - b_i;
            5'b00010: alu_res = a_i & b_i;
            5'b00011: alu_res = a_i | b_i;
            5'b00100: alu_res = a_i ^ b_i;
            5'b00101: alu_res = a_i << shamt;
            5'b00110: alu_res = a_i >> shamt;
            5'b00111: alu_res = XLEN'($signed(a_i) >>> shamt);
            5'b01000: alu_res = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            5'b01001: alu_res = {{(XLEN-1){1'b0}}, a_i < b_i};
            5'b01010: alu_res = b_i;
            5'b01011: alu_res = link_i;
            default:  alu_legal = 1'b0;
        endcase
    end

`ifdef EX_MULDIV_EN
    logic [2*XLEN-1:0] acc, acc_step, prod;
    logic [XLEN-1:0]   mag, mag_a, mag_b, md_res, quo, rem;
    logic [XLEN:0]     mul_sum, div_trial;
    logic [SHW-1:0]    cnt;
    logic [2:0]        md_op;
    logic              neg_q, neg_r, div0, sgn_a, sgn_b, last;

    assign is_md       = (op_i[4:3] == 2'b10);
    assign op_legal    = alu_legal || is_md;
    assign start_state = is_md ? BUSY : DONE;
    assign last        = (cnt == SHW'(XLEN-1));

    // Both mul and div iterate on magnitudes; the sign is applied on the final cycle.
    always_comb begin
        if (op_i[2]) begin
            sgn_a = ~op_i[0] & a_i[XLEN-1];
            sgn_b = ~op_i[0] & b_i[XLEN-1];
        end else begin
            sgn_a = (op_i[1:0] == 2'b01 || op_i[1:0] == 2'b10) & a_i[XLEN-1];
            sgn_b = (op_i[1:0] == 2'b01) & b_i[XLEN-1];
        end
        mag_a = sgn_a ? -a_i : a_i;
        mag_b = sgn_b ? -b_i : b_i;
    end

    // acc holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag} : '0);
        div_trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, mag};
        if (!md_op[2])
            acc_step = {mul_sum, acc[XLEN-1:1]};
        else if (div_trial[XLEN])
            acc_step = {acc[2*XLEN-2:0], 1'b0};
        else
            acc_step = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end

    always_comb begin
        prod = neg_q ? -acc_step : acc_step;
        quo  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        rem  = neg_r ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
        case (md_op)
            3'b000:                md_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: md_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:        md_res = div0 ? '1 : quo;
            default:               md_res = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            mag   <= '0;
            cnt   <= '0;
            md_op <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            div0  <= 1'b0;
        end else if (accept && is_md) begin
            cnt   <= '0;
            md_op <= op_i[2:0];
            div0  <= (b_i == '0);
            neg_q <= sgn_a ^ sgn_b;
            neg_r <= sgn_a;
            acc   <= {{XLEN{1'b0}}, op_i[2] ? mag_a : mag_b};
            mag   <= op_i[2] ? mag_b : mag_a;
        end else if (state == BUSY) begin
            acc <= acc_step;
            cnt <= cnt + SHW'(1);
        end
    end
`else
    assign is_md       = 1'b0;
    assign op_legal    = alu_legal;
    assign start_state = DONE;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = start_state;
`ifdef EX_MULDIV_EN
            BUSY: if (last) state_nxt = DONE;
`endif
            DONE: if (out_ready) state_nxt = accept ? start_state : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) || (state == DONE && out_ready);
        out_valid = (state == DONE);
`ifdef EX_MULDIV_EN
        busy      = (state == BUSY);
`else
        busy      = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data    <= '0;
            out_rd      <= '0;
            out_we      <= 1'b0;
            out_illegal <= 1'b0;
        end else if (accept) begin
            out_rd      <= rd_i;
            out_we      <= we_i && op_legal;
            out_illegal <= !op_legal;
            if (!is_md) out_data <= alu_legal ? alu_res : '0;
        end
`ifdef EX_MULDIV_EN
        else if (state == BUSY && last) begin
            out_data <= md_res;
        end
`endif
    end
endmodule

// File: tb/tb_ex_unit_mc.sv
// Self-checking bench for ex_unit_mc: directed cases plus random ops against an arithmetic model.
// Mul/div expectations follow EX_MULDIV_EN the same way the design build does.
module tb_ex_unit_mc;
    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int MAXWAIT = 100;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [4:0]         op_i = '0;
    logic [XLEN-1:0]    a_i = '0, b_i = '0, link_i = '0;
    logic [RADDR_W-1:0] rd_i = '0;
    logic               we_i = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [XLEN-1:0]    out_data;
    logic [RADDR_W-1:0] out_rd;
    logic               out_we, out_illegal, busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_unit_mc #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_i(op_i), .a_i(a_i), .b_i(b_i), .link_i(link_i), .rd_i(rd_i), .we_i(we_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_we(out_we), .out_illegal(out_illegal), .busy(busy)
    );

    function automatic void ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] link, output logic [31:0] d,
                                      output logic ill, output int lat);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = a;
        ib = b;
        d = '0; ill = 1'b0; lat = 1; p = '0;
        case (op)
            5'd0:  d = a + b;
            5'd1:  d = a - b;
            5'd2:  d = a & b;
            5'd3:  d = a | b;
            5'd4:  d = a ^ b;
            5'd5:  d = a << b[4:0];
            5'd6:  d = a >> b[4:0];
            5'd7:  d = 32'($signed(a) >>> b[4:0]);
            5'd8:  d = (ia < ib) ? 32'd1 : 32'd0;
            5'd9:  d = (a < b) ? 32'd1 : 32'd0;
            5'd10: d = b;
            5'd11: d = link;
`ifdef EX_MULDIV_EN
            5'd16: begin p = 64'(ua * ub); d = p[31:0];  lat = 33; end
            5'd17: begin p = 64'(sa * sb); d = p[63:32]; lat = 33; end
            5'd18: begin p = 64'(sa * ub); d = p[63:32]; lat = 33; end
            5'd19: begin p = 64'(ua * ub); d = p[63:32]; lat = 33; end
            5'd20: begin
                lat = 33;
                if (b == 0) d = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) d = a;
                else d = 32'(ia / ib);
            end
            5'd21: begin lat = 33; d = (b == 0) ? 32'hFFFFFFFF : a / b; end
            5'd22: begin
                lat = 33;
                if (b == 0) d = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) d = 0;
                else d = 32'(ia % ib);
            end
            5'd23: begin lat = 33; d = (b == 0) ? a : a % b; end
`endif
            default: ill = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op with out_ready high and report what came back (latency counted from accept edge).
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] link, input logic [4:0] rd, input logic we,
                         output int lat, output logic [31:0] d, output logic [4:0] rdo,
                         output logic weo, output logic ill, output int busy_n);
        int w;
        lat = -1; d = '0; rdo = '0; weo = 1'b0; ill = 1'b0; busy_n = 0;
        out_ready = 1'b1;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < MAXWAIT) begin
            @(negedge clk);
            w++;
        end
        in_valid = 1'b1; op_i = op; a_i = a; b_i = b; link_i = link; rd_i = rd; we_i = we;
        @(negedge clk);
        in_valid = 1'b0; op_i = 5'($urandom); a_i = $urandom; b_i = $urandom;
        link_i = $urandom; rd_i = 5'($urandom); we_i = 1'($urandom);
        for (int n = 1; n <= MAXWAIT; n++) begin
            if (busy) busy_n++;
            if (out_valid) begin
                lat = n; d = out_data; rdo = out_rd; weo = out_we; ill = out_illegal;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 32'h0)   begin bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        total++; if (out_rd !== 5'h0)      begin bad++; $display("FAIL reset_out_rd: got %h want 0", out_rd); end
        total++; if (out_we !== 1'b0)      begin bad++; $display("FAIL reset_out_we: got %b want 0", out_we); end
        total++; if (out_illegal !== 1'b0) begin bad++; $display("FAIL reset_out_illegal: got %b want 0", out_illegal); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (in_ready !== 1'b1)    begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_base_directed();
        logic [4:0]  ops [4] = '{5'd0, 5'd1, 5'd7, 5'd9};
        logic [31:0] as  [4] = '{32'h7FFFFFFF, 32'h0, 32'h80000000, 32'h1};
        logic [31:0] bs  [4] = '{32'h1, 32'h1, 32'h21, 32'hFFFFFFFF};
        logic [31:0] exp [4] = '{32'h80000000, 32'hFFFFFFFF, 32'hC0000000, 32'h1};
        int lat, bn;
        logic [31:0] d;
        logic [4:0] rdo;
        logic weo, ill;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], as[i], bs[i], 32'h0, 5'(i + 3), 1'b1, lat, d, rdo, weo, ill, bn);
            total++; if (lat !== 1) begin bad++; $display("FAIL base_lat op%0d: got %0d want 1", ops[i], lat); end
            total++; if (d !== exp[i]) begin bad++; $display("FAIL base_data op%0d: got %h want %h", ops[i], d, exp[i]); end
            total++; if (rdo !== 5'(i + 3) || weo !== 1'b1 || ill !== 1'b0)
                begin bad++; $display("FAIL base_tag op%0d: got rd=%0d we=%b ill=%b want rd=%0d we=1 ill=0", ops[i], rdo, weo, ill, i + 3); end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  ops [3] = '{5'd0, 5'd2, 5'd11};
        logic [31:0] as [3], bs [3], ls [3], exp [3];
        logic ill;
        int lat, w;
        for (int i = 0; i < 3; i++) begin
            as[i] = $urandom; bs[i] = $urandom; ls[i] = $urandom;
            ref_model(ops[i], as[i], bs[i], ls[i], exp[i], ill, lat);
        end
        out_ready = 1'b1;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < MAXWAIT) begin @(negedge clk); w++; end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; op_i = ops[i]; a_i = as[i]; b_i = bs[i]; link_i = ls[i];
            rd_i = 5'(i + 1); we_i = 1'b1;
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_data !== exp[i] || out_rd !== 5'(i + 1))
                begin bad++; $display("FAIL b2b_result%0d: got v=%b d=%h rd=%0d want v=1 d=%h rd=%0d", i, out_valid, out_data, out_rd, exp[i], i + 1); end
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready%0d: got %b want 1", i, in_ready); end
        end
        // Stall the consumer while junk is offered; the LINK result must hold.
        out_ready = 1'b0; op_i = 5'd0; a_i = $urandom; b_i = $urandom; rd_i = 5'd30;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_data !== exp[2] || out_rd !== 5'd3 || in_ready !== 1'b0)
                begin bad++; $display("FAIL stall_hold%0d: got v=%b d=%h rd=%0d rdy=%b want v=1 d=%h rd=3 rdy=0", k, out_valid, out_data, out_rd, in_ready, exp[2]); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_release: got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_illegal();
`ifdef EX_MULDIV_EN
        logic [4:0] ops [2] = '{5'b11111, 5'b11000};
`else
        logic [4:0] ops [2] = '{5'b11111, 5'b10000};
`endif
        int lat, bn;
        logic [31:0] d;
        logic [4:0] rdo;
        logic weo, ill;
        for (int i = 0; i < 2; i++) begin
            do_op(ops[i], 32'h12345678, 32'h9ABCDEF0, 32'h5555AAAA, 5'd9, 1'b1, lat, d, rdo, weo, ill, bn);
            total++;
            if (lat !== 1 || ill !== 1'b1 || weo !== 1'b0 || d !== 32'h0 || rdo !== 5'd9)
                begin bad++; $display("FAIL illegal op%b: got lat=%0d ill=%b we=%b d=%h rd=%0d want lat=1 ill=1 we=0 d=0 rd=9", ops[i], lat, ill, weo, d, rdo); end
        end
    endtask

`ifdef EX_MULDIV_EN
    task automatic test_muldiv();
        logic [4:0]  ops [8] = '{5'd17, 5'd19, 5'd20, 5'd23, 5'd21, 5'd16, 5'd22, 5'd18};
        logic [31:0] as  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'd7, 32'd7, 32'd3, 32'hFFFFFFF9, 32'hFFFFFFFF};
        logic [31:0] bs  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFB, 32'd2, 32'd2};
        logic [31:0] exp [8] = '{32'h0, 32'hFFFFFFFE, 32'h80000000, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFF1, 32'hFFFFFFFF, 32'hFFFFFFFF};
        int lat, bn;
        logic [31:0] d;
        logic [4:0] rdo;
        logic weo, ill;
        for (int i = 0; i < 8; i++) begin
            do_op(ops[i], as[i], bs[i], 32'h0, 5'd17, 1'b1, lat, d, rdo, weo, ill, bn);
            total++; if (lat !== 33 || bn !== 32)
                begin bad++; $display("FAIL md_timing op%0d: got lat=%0d busy=%0d want lat=33 busy=32", ops[i], lat, bn); end
            total++; if (d !== exp[i] || ill !== 1'b0 || weo !== 1'b1)
                begin bad++; $display("FAIL md_data op%0d: got %h ill=%b we=%b want %h ill=0 we=1", ops[i], d, ill, weo, exp[i]); end
        end
    endtask
`endif

    task automatic test_random();
        logic [4:0] op, rd;
        logic [31:0] a, b, l, d, ed;
        logic [4:0] rdo;
        logic weo, ill, eill, we;
        int lat, elat, bn, r;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      op = 5'($urandom_range(0, 11));
            else if (r < 8) op = 5'(16 + $urandom_range(0, 7));
            else            op = 5'($urandom);
            a = pick(); b = pick(); l = $urandom; rd = 5'($urandom); we = 1'($urandom);
            ref_model(op, a, b, l, ed, eill, elat);
            do_op(op, a, b, l, rd, we, lat, d, rdo, weo, ill, bn);
            total++;
            if (lat !== elat || d !== ed || ill !== eill || rdo !== rd || weo !== (we & ~eill))
                begin bad++; $display("FAIL rand%0d op%b a=%h b=%h: got lat=%0d d=%h ill=%b rd=%0d we=%b want lat=%0d d=%h ill=%b rd=%0d we=%b",
                                      i, op, a, b, lat, d, ill, rdo, weo, elat, ed, eill, rd, we & ~eill); end
        end
    endtask

    task automatic test_reset_mid();
        int w;
        bit seen;
        out_ready = 1'b1;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < MAXWAIT) begin @(negedge clk); w++; end
        in_valid = 1'b1; a_i = 32'd1000; b_i = 32'd7; rd_i = 5'd4; we_i = 1'b1;
`ifdef EX_MULDIV_EN
        op_i = 5'd20;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy: got %b want 1", busy); end
`else
        op_i = 5'd0;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== 32'h0)
            begin bad++; $display("FAIL midrst_state: got v=%b rdy=%b busy=%b d=%h want v=0 rdy=1 busy=0 d=0", out_valid, in_ready, busy, out_data); end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_no_result: got out_valid seen=%b want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_base_directed();
        test_back_to_back();
        test_illegal();
`ifdef EX_MULDIV_EN
        test_muldiv();
`endif
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ex_unit_mc.md
# ex_unit_mc

Parametrised multi-cycle execute unit for the RISC-V core. It replaces the single-cycle combinational ALU with a registered, valid/ready-handshaked unit. Base integer ops complete in one cycle. Optional RV32M multiply/divide runs iteratively. It sits between decode/operand fetch and memory/writeback, and carries the destination register tag and write-enable alongside the result.

## Interface
- XLEN, 32, datapath width; power of two, ≥8
- RADDR_W, 5, destination register index width
- SHW, $clog2(XLEN), derived local: shift-amount width
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept this cycle
- op_i  in  5  operation code, see Operation
- a_i, b_i  in  XLEN  source operands
- link_i  in  XLEN  return address for jumps
- rd_i  in  RADDR_W  destination register
- we_i  in  1  register write request
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_data  out  XLEN  result
- out_rd  out  RADDR_W  captured rd_i
- out_we  out  1  captured we_i, forced 0 if illegal
- out_illegal  out  1  op_i was unsupported
- busy  out  1  iterative op in progress

## Operation
- Op codes:
  - 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 XOR.
  - 00101 SLL, 00110 SRL, 00111 SRA.
  - 01000 SLT (signed), 01001 SLTU.
  - 01010 PASSB (LUI), 01011 LINK (out_data = link_i).
  - 10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU.
  - 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
  - All other codes are illegal.
- Shifts use b_i[SHW-1:0]. SRA sign-fills from a_i[XLEN-1].
- Arithmetic is modulo 2^XLEN. SLT/SLTU return 1 or 0, zero-extended.
- States:
  - IDLE→DONE on accept of a base or illegal op.
  - IDLE→BUSY on accept of a mul/div op.
  - BUSY→DONE after XLEN iterations.
  - DONE→IDLE when out_ready is high and no new accept.
  - DONE→DONE/BUSY when out_ready is high and a new op is accepted in the same cycle.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Accept occurs when in_valid && in_ready. All inputs are captured at accept. Inputs are ignored at other times.
- Multiply: shift-add, one partial-product bit per cycle, 2·XLEN product. MUL returns the low half; MULH/MULHSU/MULHU return the high half with signed×signed, signed×unsigned, and unsigned×unsigned operands respectively.
- Divide: restoring, one quotient bit per cycle, on magnitudes with the sign fixed up at the end.
- Divide by zero: quotient is all ones; remainder is a_i.
- Signed overflow (−2^(XLEN−1) / −1): quotient is a_i; remainder is 0.
- Both special cases still take the full XLEN+1 latency.
- Illegal op: out_illegal=1, out_data=0, out_we=0, latency 1.

## Timing
- Reset values: out_valid=0, out_data=0, out_rd=0, out_we=0, out_illegal=0, busy=0, state IDLE. in_ready is 1 the cycle after reset.
- Reset mid-operation aborts the op. No out_valid is produced for it.
- Base-op latency: out_valid rises the cycle after accept.
- Mul/div latency: out_valid rises XLEN+1 cycles after accept. busy is high for the XLEN BUSY cycles.
- Throughput: one base op per cycle while out_ready is held high.
- Output hold: out_* hold stable while out_valid && !out_ready.
- out_valid drops the cycle after the handshake unless a new result completes that cycle.
- Only one op is outstanding at a time; the unit never reorders.

## Configuration
- EX_MULDIV_EN defined: mul/div ops are implemented as above.
- EX_MULDIV_EN undefined:
  - Codes 10000–10111 are illegal, with 1-cycle latency.
  - The BUSY state and iteration counter are removed, and busy is tied to 0.

## Test plan
- ADD a=0x7FFFFFFF, b=1 → out_data 0x80000000 one cycle after accept. SUB 0 − 1 → 0xFFFFFFFF.
- SRA a=0x80000000, b=0x21 (shamt 1) → 0xC0000000. SLTU a=1, b=0xFFFFFFFF → 1.
- Back-to-back ADD, AND, LINK with out_ready=1 → three results on consecutive cycles. Stall out_ready for 3 cycles → outputs held and in_ready=0.
- With EX_MULDIV_EN:
  - MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000 after 33 cycles.
  - MULHU on the same operands → 0xFFFFFFFE.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REMU 7 / 0 → 7.
  - DIVU 7 / 0 → 0xFFFFFFFF.
- Reset asserted on the 10th BUSY cycle of a DIV → no out_valid. The unit is IDLE with in_ready=1 the next cycle.
- op 11111, and MUL without EX_MULDIV_EN → out_illegal=1, out_we=0, out_data=0 after 1 cycle.
